// File: rtl/polygon_loader.sv
// polygon_loader: collects a serial stream of signed vertices into a shadow
// bank and copies it to the active bank only on a frame boundary. The
// downstream per-pixel test therefore only ever sees complete polygons.
// Optional build macro: CAMERA_OFFSET_EN. When it is defined, each vertex is
// stored relative to the camera position sampled on its accept cycle.
module polygon_loader #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    localparam int CNT_W           = $clog2(MAX_NUM_VERTICES + 1)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         vert_valid_in,
    output logic                         vert_ready_out,
    input  logic signed [WORLD_BITS-1:0] vert_x_in,
    input  logic signed [WORLD_BITS-1:0] vert_y_in,
    input  logic                         vert_last_in,
    input  logic                         frame_start_in,
    input  logic signed [WORLD_BITS-1:0] camera_x_in,
    input  logic signed [WORLD_BITS-1:0] camera_y_in,
    output logic signed [WORLD_BITS-1:0] poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [WORLD_BITS-1:0] poly_ys_out [MAX_NUM_VERTICES],
    output logic [CNT_W-1:0]             num_points_out,
    output logic                         swap_out,
    output logic                         error_out
);

    typedef logic signed [WORLD_BITS-1:0] coord_t;
    typedef enum logic {FILL = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_NUM_VERTICES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] shadow_count_q, shadow_count_d;
    logic [CNT_W-1:0] num_points_q, num_points_d;
    logic             ready_q, ready_d;
    logic             swap_fire_q, swap_fire_d;
    logic             swap_q, swap_d;
    logic             error_q, error_d;
    coord_t           shadow_x_q [MAX_NUM_VERTICES];
    coord_t           shadow_y_q [MAX_NUM_VERTICES];
    coord_t           shadow_x_d [MAX_NUM_VERTICES];
    coord_t           shadow_y_d [MAX_NUM_VERTICES];
    coord_t           active_x_q [MAX_NUM_VERTICES];
    coord_t           active_y_q [MAX_NUM_VERTICES];
    coord_t           active_x_d [MAX_NUM_VERTICES];
    coord_t           active_y_d [MAX_NUM_VERTICES];

    coord_t           store_x;
    coord_t           store_y;
    logic             accept;
    logic [CNT_W-1:0] final_count;

`ifdef CAMERA_OFFSET_EN
    // Camera-relative coordinates; subtraction wraps at WORLD_BITS.
    assign store_x = vert_x_in - camera_x_in;
    assign store_y = vert_y_in - camera_y_in;
`else
    logic unused_camera;
    assign unused_camera = ^{camera_x_in, camera_y_in};
    assign store_x = vert_x_in;
    assign store_y = vert_y_in;
`endif

    assign accept = vert_valid_in && ready_q;
    // Count the polygon would have if this beat closed it; overflow beats add nothing.
    assign final_count = (idx_q < CAP) ? idx_q + 1'b1 : CAP;

    // Next-state logic: fill the shadow, commit on last, swap on frame boundary.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_count_d = shadow_count_q;
        num_points_d   = num_points_q;
        swap_fire_d    = 1'b0;
        swap_d         = swap_fire_q;
        error_d        = error_q;
        shadow_x_d     = shadow_x_q;
        shadow_y_d     = shadow_y_q;
        active_x_d     = active_x_q;
        active_y_d     = active_y_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q < CAP) begin
                        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                            if (idx_q == CNT_W'(i)) begin
                                shadow_x_d[i] = store_x;
                                shadow_y_d[i] = store_y;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    if (vert_last_in) begin
                        if (final_count >= CNT_W'(3)) begin
                            shadow_count_d = final_count;
                            state_d        = PENDING;
                        end else begin
                            // Degenerate polygon: drop it and start over.
                            error_d    = 1'b1;
                            idx_d      = '0;
                            shadow_x_d = '{default: '0};
                            shadow_y_d = '{default: '0};
                        end
                    end
                end
            end
            PENDING: begin
                if (frame_start_in) begin
                    active_x_d   = shadow_x_q;
                    active_y_d   = shadow_y_q;
                    num_points_d = shadow_count_q;
                    shadow_x_d   = '{default: '0};
                    shadow_y_d   = '{default: '0};
                    idx_d        = '0;
                    state_d      = FILL;
                    swap_fire_d  = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase

        ready_d = (state_d == FILL);
    end

    // State and bank registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= FILL;
            idx_q          <= '0;
            shadow_count_q <= '0;
            num_points_q   <= '0;
            ready_q        <= 1'b1;
            swap_fire_q    <= 1'b0;
            swap_q         <= 1'b0;
            error_q        <= 1'b0;
            shadow_x_q     <= '{default: '0};
            shadow_y_q     <= '{default: '0};
            active_x_q     <= '{default: '0};
            active_y_q     <= '{default: '0};
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_count_q <= shadow_count_d;
            num_points_q   <= num_points_d;
            ready_q        <= ready_d;
            swap_fire_q    <= swap_fire_d;
            swap_q         <= swap_d;
            error_q        <= error_d;
            shadow_x_q     <= shadow_x_d;
            shadow_y_q     <= shadow_y_d;
            active_x_q     <= active_x_d;
            active_y_q     <= active_y_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_NUM_VERTICES; gi++) begin : g_out
            assign poly_xs_out[gi] = active_x_q[gi];
            assign poly_ys_out[gi] = active_y_q[gi];
        end
    endgenerate

    // swap_out is delayed one cycle from the edge that loaded the active bank.
    assign swap_out       = swap_q;
    assign vert_ready_out = ready_q;
    assign num_points_out = num_points_q;
    assign error_out      = error_q;

endmodule
